// File: rtl/measure_scheduler.sv
// Round-robin edge-count scheduler: one shared rising-edge counter is gated onto
// each enabled input line in turn, and each count is published over valid/ready.
module measure_scheduler #(
    parameter int CHANNELS    = 4,
    parameter int GATE_CYCLES = 1000,
    parameter int WIDTH       = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [CHANNELS-1:0]         chan_mask,
    input  logic [CHANNELS-1:0]         sig_in,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [WIDTH-1:0]            res_data,
    output logic [$clog2(CHANNELS)-1:0] res_chan,
    output logic                        res_sat
);

    localparam int CW = $clog2(CHANNELS);
    localparam int TW = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SELECT, GATE, PUBLISH} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     sel_q, sel_d;
    logic [CW-1:0]     last_q, last_d;
    logic              prev_q, prev_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              sat_q, sat_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic              rsat_q, rsat_d;
    logic [CW-1:0]     grant_s;
    logic              edge_s;

    // First set mask bit strictly after 'last', wrapping; only used when mask is non-zero.
    function automatic logic [CW-1:0] rr_pick(input logic [CHANNELS-1:0] mask,
                                              input logic [CW-1:0]       last);
        logic [CW-1:0] pick;
        logic [CW-1:0] cand;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = CW'((int'(last) + i) % CHANNELS);
            if (!found && mask[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next-state and datapath logic for the select/gate/publish sequence.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        prev_d  = prev_q;
        count_d = count_q;
        sat_d   = sat_q;
        timer_d = timer_q;
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        rsat_d  = rsat_q;
        grant_s = rr_pick(chan_mask, last_q);
        edge_s  = sig_in[sel_q] && !prev_q;

        case (state_q)
            IDLE: begin
                if (enable && |chan_mask) begin
                    state_d = SELECT;
                end else begin
                    state_d = IDLE;
                end
            end
            SELECT: begin
                if (|chan_mask) begin
                    sel_d   = grant_s;
                    last_d  = grant_s;
                    prev_d  = sig_in[grant_s];
                    count_d = '0;
                    sat_d   = 1'b0;
                    timer_d = '0;
                    state_d = GATE;
                end else begin
                    state_d = IDLE;
                end
            end
            GATE: begin
                prev_d = sig_in[sel_q];
                if (edge_s) begin
                    if (&count_q) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    count_d = count_q;
                end
                // The final gate cycle's edge is folded into the published count.
                if (timer_q == TW'(GATE_CYCLES - 1)) begin
                    state_d = PUBLISH;
                    valid_d = 1'b1;
                    data_d  = count_d;
                    chan_d  = sel_q;
                    rsat_d  = sat_d;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PUBLISH: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = (enable && |chan_mask) ? SELECT : IDLE;
                end else begin
                    state_d = PUBLISH;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any result in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= CW'(CHANNELS - 1);
            prev_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            rsat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            rsat_q  <= rsat_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = valid_q;
    assign res_data  = data_q;
    assign res_chan  = chan_q;
    assign res_sat   = rsat_q;

endmodule

// File: tb/tb_measure_scheduler.sv
// Directed bench: instance A (10-cycle gate, 64-bit count) covers scheduling,
// handshake and reset; instance B (40-cycle gate, 4-bit count) covers saturation.
module tb_measure_scheduler;

    logic clk;
    logic tog;
    int   n_checks;
    int   n_fail;

    logic        rst_a, enable_a, ready_a;
    logic [3:0]  mask_a, tmask_a;
    wire  [3:0]  sig_a;
    logic        busy_a, valid_a, sat_a;
    logic [63:0] data_a;
    logic [1:0]  chan_a;

    logic        rst_b, enable_b, ready_b;
    logic [3:0]  mask_b, tmask_b;
    wire  [3:0]  sig_b;
    logic        busy_b, valid_b, sat_b;
    logic [3:0]  data_b;
    logic [1:0]  chan_b;

    assign sig_a = tmask_a & {4{tog}};
    assign sig_b = tmask_b & {4{tog}};

    measure_scheduler #(.CHANNELS(4), .GATE_CYCLES(10), .WIDTH(64)) dut_a (
        .clk(clk), .rst(rst_a), .enable(enable_a), .chan_mask(mask_a), .sig_in(sig_a),
        .busy(busy_a), .res_valid(valid_a), .res_ready(ready_a), .res_data(data_a),
        .res_chan(chan_a), .res_sat(sat_a)
    );

    measure_scheduler #(.CHANNELS(4), .GATE_CYCLES(40), .WIDTH(4)) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .chan_mask(mask_b), .sig_in(sig_b),
        .busy(busy_b), .res_valid(valid_b), .res_ready(ready_b), .res_data(data_b),
        .res_chan(chan_b), .res_sat(sat_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every enabled test line toggles once per clock, away from the sampling edge.
    initial begin
        tog = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            tog = ~tog;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_a(input int budget, output int n);
        n = 0;
        while (!valid_a && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_rst_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %0b expected 0", busy_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %0b expected 0", valid_a); end
        n_checks++; if (data_a !== 64'd0) begin n_fail++; $display("FAIL reset_data_a: got %0d expected 0", data_a); end
        n_checks++; if (chan_a !== 2'd0) begin n_fail++; $display("FAIL reset_chan_a: got %0d expected 0", chan_a); end
        n_checks++; if (sat_a !== 1'b0) begin n_fail++; $display("FAIL reset_sat_a: got %0b expected 0", sat_a); end
        n_checks++; if ({busy_b, valid_b, data_b, chan_b, sat_b} !== 9'd0) begin n_fail++; $display("FAIL reset_b: got %0h expected 0", {busy_b, valid_b, data_b, chan_b, sat_b}); end
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_single_channel();
        int n;
        pulse_rst_a();
        mask_a = 4'b0001; tmask_a = 4'b0001; ready_a = 1'b1; enable_a = 1'b1;
        tick();
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL t1_busy_select: got %0b expected 1", busy_a); end
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || n + 1 != 12) begin n_fail++; $display("FAIL t1_latency: got valid %0b after %0d cycles expected 1 after 12", valid_a, n + 1); end
        n_checks++; if (data_a !== 64'd5) begin n_fail++; $display("FAIL t1_data: got %0d expected 5", data_a); end
        n_checks++; if (chan_a !== 2'd0) begin n_fail++; $display("FAIL t1_chan: got %0d expected 0", chan_a); end
        n_checks++; if (sat_a !== 1'b0) begin n_fail++; $display("FAIL t1_sat: got %0b expected 0", sat_a); end
        tick();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL t1_valid_drop: got %0b expected 0", valid_a); end
        n_checks++; if (data_a !== 64'd5) begin n_fail++; $display("FAIL t1_data_held: got %0d expected 5", data_a); end
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || n != 11) begin n_fail++; $display("FAIL t1_throughput: got valid %0b after %0d cycles expected 1 after 11", valid_a, n); end
        n_checks++; if (data_a !== 64'd5) begin n_fail++; $display("FAIL t1_data2: got %0d expected 5", data_a); end
        tick();
        enable_a = 1'b0;
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_chan [4];
        exp_chan = '{2'd1, 2'd3, 2'd1, 2'd3};
        pulse_rst_a();
        mask_a = 4'b1010; tmask_a = 4'b0101; ready_a = 1'b1; enable_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid_a(40, n);
            n_checks++; if (valid_a !== 1'b1 || chan_a !== exp_chan[k]) begin n_fail++; $display("FAIL t2_chan[%0d]: got valid %0b chan %0d expected chan %0d", k, valid_a, chan_a, exp_chan[k]); end
            n_checks++; if (data_a !== 64'd0) begin n_fail++; $display("FAIL t2_data[%0d]: got %0d expected 0", k, data_a); end
            tick();
        end
        enable_a = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        pulse_rst_a();
        mask_a = 4'b0011; tmask_a = 4'b0001; ready_a = 1'b0; enable_a = 1'b1;
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || data_a !== 64'd5 || chan_a !== 2'd0) begin n_fail++; $display("FAIL t3_first: got valid %0b data %0d chan %0d expected 1/5/0", valid_a, data_a, chan_a); end
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (valid_a !== 1'b1 || data_a !== 64'd5 || chan_a !== 2'd0 || busy_a !== 1'b1) begin
                n_fail++;
                $display("FAIL t3_hold[%0d]: got valid %0b data %0d chan %0d busy %0b expected 1/5/0/1", k, valid_a, data_a, chan_a, busy_a);
            end
        end
        ready_a = 1'b1;
        tick();
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL t3_transfer: got valid %0b expected 0", valid_a); end
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || n != 11) begin n_fail++; $display("FAIL t3_next_gate: got valid %0b after %0d cycles expected 1 after 11", valid_a, n); end
        n_checks++; if (chan_a !== 2'd1 || data_a !== 64'd0) begin n_fail++; $display("FAIL t3_next_result: got chan %0d data %0d expected 1/0", chan_a, data_a); end
        tick();
        enable_a = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        mask_b = 4'b0001; tmask_b = 4'b0001; ready_b = 1'b1; enable_b = 1'b1;
        n = 0;
        while (!valid_b && n < 100) begin
            tick();
            n++;
        end
        n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL t4_valid: got %0b expected 1", valid_b); end
        n_checks++; if (data_b !== 4'd15) begin n_fail++; $display("FAIL t4_data: got %0d expected 15", data_b); end
        n_checks++; if (sat_b !== 1'b1) begin n_fail++; $display("FAIL t4_sat: got %0b expected 1", sat_b); end
        n_checks++; if (chan_b !== 2'd0) begin n_fail++; $display("FAIL t4_chan: got %0d expected 0", chan_b); end
        enable_b = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_gate();
        int n;
        pulse_rst_a();
        mask_a = 4'b0101; tmask_a = 4'b0101; ready_a = 1'b1; enable_a = 1'b1;
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || chan_a !== 2'd0 || data_a !== 64'd5) begin n_fail++; $display("FAIL t5_first: got valid %0b chan %0d data %0d expected 1/0/5", valid_a, chan_a, data_a); end
        tick(); tick(); tick(); tick(); tick();
        rst_a = 1'b1;
        tick();
        n_checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 64'd0 || chan_a !== 2'd0 || sat_a !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_reset: got busy %0b valid %0b data %0d chan %0d sat %0b expected all 0", busy_a, valid_a, data_a, chan_a, sat_a);
        end
        rst_a = 1'b0;
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || n != 12) begin n_fail++; $display("FAIL t5_restart: got valid %0b after %0d cycles expected 1 after 12", valid_a, n); end
        n_checks++; if (chan_a !== 2'd0 || data_a !== 64'd5) begin n_fail++; $display("FAIL t5_first_grant: got chan %0d data %0d expected 0/5", chan_a, data_a); end
        tick();
        enable_a = 1'b0;
    endtask

    task automatic test_idle_and_late_disable();
        int n;
        pulse_rst_a();
        mask_a = 4'b0000; tmask_a = 4'b0001; ready_a = 1'b1; enable_a = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            n_checks++;
            if (busy_a !== 1'b0 || valid_a !== 1'b0) begin n_fail++; $display("FAIL t6_empty_mask[%0d]: got busy %0b valid %0b expected 0/0", k, busy_a, valid_a); end
        end
        mask_a = 4'b0001;
        tick(); tick(); tick(); tick();
        enable_a = 1'b0; mask_a = 4'b0000;
        wait_valid_a(40, n);
        n_checks++; if (valid_a !== 1'b1 || data_a !== 64'd5 || chan_a !== 2'd0) begin n_fail++; $display("FAIL t6_published: got valid %0b data %0d chan %0d expected 1/5/0", valid_a, data_a, chan_a); end
        tick();
        n_checks++; if (valid_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL t6_to_idle: got valid %0b busy %0b expected 0/0", valid_a, busy_a); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0) begin n_fail++; $display("FAIL t6_stay_idle[%0d]: got busy %0b valid %0b expected 0/0", k, busy_a, valid_a); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_a = 1'b1; enable_a = 1'b0; ready_a = 1'b0; mask_a = 4'b0000; tmask_a = 4'b0000;
        rst_b = 1'b1; enable_b = 1'b0; ready_b = 1'b0; mask_b = 4'b0000; tmask_b = 4'b0000;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid_gate();
        test_idle_and_late_disable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
